// File: rtl/param_sync_fifo.sv
// rtl/param_sync_fifo.sv - parameterised synchronous FIFO with FWFT or registered-read output
//
// Parameters:
//   DATA_WIDTH  word width in bits
//   DEPTH       storage depth in words (power of two, >= 4)
//   FWFT        1 = first-word-fall-through, 0 = registered read (1-cycle latency)
//   AF_LEVEL    o_almost_full when count >= AF_LEVEL
//   AE_LEVEL    o_almost_empty when count <= AE_LEVEL
// Ports:
//   clk, rst_n                clock and synchronous active-low reset
//   i_wr_en, i_wdata          write request and data
//   i_rd_en                   read request / pop (acknowledge in FWFT mode)
//   i_clr_err                 clears the sticky error flags
//   o_rdata, o_rvalid         read data and its valid
//   o_full, o_empty           count == DEPTH / count == 0
//   o_almost_full/empty       threshold flags
//   o_count                   stored words, 0..DEPTH
//   o_overflow, o_underflow   sticky error flags
module param_sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int FWFT       = 1,
    parameter int AF_LEVEL   = DEPTH - 2,
    parameter int AE_LEVEL   = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_wr_en,
    input  logic [DATA_WIDTH-1:0]       i_wdata,
    input  logic                        i_rd_en,
    input  logic                        i_clr_err,
    output logic [DATA_WIDTH-1:0]       o_rdata,
    output logic                        o_rvalid,
    output logic                        o_full,
    output logic                        o_empty,
    output logic                        o_almost_full,
    output logic                        o_almost_empty,
    output logic [$clog2(DEPTH):0]      o_count,
    output logic                        o_overflow,
    output logic                        o_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_LEVEL);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_LEVEL);
    localparam logic [AW:0] ONE_C   = (AW+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wr_ptr;
    logic [AW:0]           rd_ptr;
    logic [AW:0]           count;
    logic                  wr_acc;
    logic                  rd_acc;

    assign o_count        = count;
    assign o_full         = (count == DEPTH_C);
    assign o_empty        = (count == '0);
    assign o_almost_full  = (count >= AF_C);
    assign o_almost_empty = (count <= AE_C);

    // A read frees a slot in the same cycle, so a full FIFO still takes a
    // write when it is also being popped.
    assign rd_acc = i_rd_en && !o_empty;
    assign wr_acc = i_wr_en && (!o_full || rd_acc);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + ONE_C;
            if (rd_acc) rd_ptr <= rd_ptr + ONE_C;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
            // A new error event in the clearing cycle keeps the flag set.
            o_overflow  <= (o_overflow  && !i_clr_err) || (i_wr_en && o_full && !rd_acc);
            o_underflow <= (o_underflow && !i_clr_err) || (i_rd_en && o_empty);
        end
    end

    // Storage array carries no reset so it maps onto RAM.
    always_ff @(posedge clk) begin
        if (rst_n && wr_acc) mem[wr_ptr[AW-1:0]] <= i_wdata;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign o_rdata  = mem[rd_ptr[AW-1:0]];
            assign o_rvalid = !o_empty;
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] rdata_q;
            logic                  rvalid_q;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    rdata_q  <= '0;
                    rvalid_q <= 1'b0;
                end else begin
                    rvalid_q <= rd_acc;
                    if (rd_acc) rdata_q <= mem[rd_ptr[AW-1:0]];
                end
            end
            assign o_rdata  = rdata_q;
            assign o_rvalid = rvalid_q;
        end
    endgenerate

endmodule

// File: doc/param_sync_fifo.md
PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, the word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 16, the storage depth in words; it must be a power of two, >=4; AW = log2(DEPTH).
REQ-003 SHALL have parameter FWFT, default 1; 1 selects first-word-fall-through, 0 selects standard registered-read.
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-2; o_almost_full asserts when count >= AF_LEVEL.
REQ-005 SHALL have parameter AE_LEVEL, default 2; o_almost_empty asserts when count <= AE_LEVEL.
REQ-006 SHALL have port clk, input, 1 bit: the clock; all logic is on the rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-008 SHALL have port i_wr_en, input, 1 bit: write request.
REQ-009 SHALL have port i_wdata, input, DATA_WIDTH bits: write data.
REQ-010 SHALL have port i_rd_en, input, 1 bit: read request / pop.
REQ-011 SHALL have port i_clr_err, input, 1 bit: clears the sticky error flags.
REQ-012 SHALL have port o_rdata, output, DATA_WIDTH bits: read data.
REQ-013 SHALL have port o_rvalid, output, 1 bit: o_rdata is valid.
REQ-014 SHALL have port o_full, output, 1 bit: count == DEPTH.
REQ-015 SHALL have port o_empty, output, 1 bit: count == 0.
REQ-016 SHALL have port o_almost_full, output, 1 bit.
REQ-017 SHALL have port o_almost_empty, output, 1 bit.
REQ-018 SHALL have port o_count, output, AW+1 bits: the number of stored words, 0..DEPTH.
REQ-019 SHALL have port o_overflow, output, 1 bit: sticky flag for a write while full.
REQ-020 SHALL have port o_underflow, output, 1 bit: sticky flag for a read while empty.

Function
REQ-021 SHALL hold the full DEPTH words; pointers are AW+1 bits, with the MSB acting as the wrap bit; full is asserted when the pointer LSBs are equal and the MSBs differ.
REQ-022 SHALL accept a write (wr_acc) when i_wr_en && (!o_full || rd_acc); it then stores i_wdata at wr_ptr[AW-1:0] and increments wr_ptr modulo 2^(AW+1).
REQ-023 SHALL accept a read (rd_acc) when i_rd_en && !o_empty, evaluated on the flags at the start of the cycle; it then increments rd_ptr.
REQ-024 SHALL, when full with simultaneous i_wr_en and i_rd_en, accept both; count stays DEPTH, no overflow is raised, and the read returns the old word.
REQ-025 SHALL, when empty with simultaneous i_wr_en and i_rd_en, accept the write only, reject the read, set o_underflow, and make count 1.
REQ-026 SHALL register o_count: +1 on a write only, -1 on a read only, unchanged on both or neither; o_full, o_empty and the almost flags are derived combinationally from the registered count.
REQ-027 SHALL, with FWFT=1, drive o_rdata = mem[rd_ptr] combinationally and o_rvalid = !o_empty, giving zero-cycle latency; i_rd_en acts as an acknowledge of the presented word.
REQ-028 SHALL, with FWFT=0, register o_rdata on rd_acc to mem[rd_ptr], with o_rvalid high for exactly the cycle after each rd_acc; o_rdata holds its value otherwise, and the latency is 1 cycle.
REQ-029 SHALL set o_overflow on i_wr_en && o_full && !rd_acc; the FIFO contents and pointers are unchanged.
REQ-030 SHALL set o_underflow on i_rd_en && o_empty.
REQ-031 SHALL clear both sticky flags on i_clr_err; a new error event in the same cycle wins and the flag stays set.
REQ-032 SHALL let both pointers wrap through 2*DEPTH with no data loss; ordering is strict FIFO.
REQ-033 SHALL infer the storage as RAM with no reset on the memory array.

Reset
REQ-034 SHALL, while rst_n=0 at a clock edge, set wr_ptr=0, rd_ptr=0, o_count=0, o_overflow=0, o_underflow=0, the registered o_rdata=0 (FWFT=0), and o_rvalid=0.
REQ-035 SHALL, after reset, present o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0.
REQ-036 SHALL, on reset mid-operation, discard all stored words; any write or read in the reset cycle is ignored.

Verification
REQ-037 SHALL pass this scenario (DEPTH=4, FWFT=1): write A,B,C,D -> o_full=1 and count=4 after the 4th edge; o_rdata=A with no read issued; 4 reads return A,B,C,D, then o_empty=1.
REQ-038 SHALL pass this scenario: when full, a write of E -> o_overflow=1, count stays 4, and the read sequence is still A..D; i_clr_err -> o_overflow=0 on the next cycle.
REQ-039 SHALL pass this scenario: when full, simultaneous write E and read -> count=4, the read returns A, and the FIFO then holds B,C,D,E.
REQ-040 SHALL pass this scenario: when empty, simultaneous write X and read -> o_underflow=1, count=1, o_rdata=X (FWFT=1).
REQ-041 SHALL pass this scenario (FWFT=0): write 0x11,0x22, then read on two consecutive cycles -> o_rvalid is high on the two following cycles with o_rdata=0x11 then 0x22.
REQ-042 SHALL pass this scenario: 3*DEPTH random pushes and pops with reset asserted mid-stream -> a scoreboard match, all flags consistent with the count, and after reset count=0 and o_empty=1.
